// File: rtl/mem_access_stage.sv
// Purpose : MEM stage. Performs the EX/MEM load/store against an internal RAM of 32-bit words.
//           Supports byte, half and word access, little-endian, with load sign/zero extension.
// Latency : DONE is entered WAIT_CYCLES+1 edges after the request. ReadData_out is registered on that edge.
// Backpr. : Stall_out holds the upstream pipeline through IDLE-with-request and WAIT.
//           It drops in DONE, so the pipeline advances at the end of DONE.
//
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   MemRead_in      - load request
//   MemWrite_in     - store request (wins when both are high)
//   MemSize_in      - 00 byte, 01 half, 10/11 word
//   MemUnsigned_in  - 1 zero-extends loads, 0 sign-extends
//   Addr_in         - byte address; bits above ADDR_BITS+1 are ignored (wraps)
//   WriteData_in    - right-aligned store data
//   ReadData_out    - extended load result (0 after a store), held between accesses
//   Stall_out       - freeze request to PC/IF/ID/EX stages
//   Misalign_out    - misaligned-access flag
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   Defined   : flags misaligned half/word requests and refuses them.
//   Undefined : Misalign_out is tied 0 and low address bits are masked.
module mem_access_stage #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [1:0]  MemSize_in,
  input  logic        MemUnsigned_in,
  input  logic [31:0] Addr_in,
  input  logic [31:0] WriteData_in,
  output logic [31:0] ReadData_out,
  output logic        Stall_out,
  output logic        Misalign_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   enter_done;
  logic                   req;
  logic                   is_store;
  logic                   misalign;
  logic [ADDR_BITS-1:0]   word_idx;

  logic [31:0]            mem [0:(2**ADDR_BITS)-1];
  logic [31:0]            rd_word;
  logic [7:0]             rd_byte;
  logic [15:0]            rd_half;
  logic [31:0]            load_ext;
  logic [3:0]             wr_be;
  logic [31:0]            wr_lanes;

  // Upper address bits are deliberately dropped so accesses alias modulo RAM size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^Addr_in[31:ADDR_BITS+2];

  assign req      = MemRead_in | MemWrite_in;
  assign is_store = MemWrite_in;
  assign word_idx = Addr_in[ADDR_BITS+1:2];

`ifdef MEM_MISALIGN_TRAP_EN
  // Only a fresh request in IDLE is judged. A refused request never leaves IDLE.
  assign misalign = (state_q == S_IDLE) && req &&
                    (((MemSize_in == 2'b01) && Addr_in[0]) ||
                     (MemSize_in[1] && (Addr_in[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign Misalign_out = misalign;

  // Combinational stall, so the request cycle itself is already frozen.
  assign Stall_out = ((state_q == S_IDLE) && req && !misalign) || (state_q == S_WAIT);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && !misalign) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LD;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = S_DONE;
          enter_done = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------- lane selection
  // Store lanes. Data is replicated across lanes so a byte enable alone selects placement.
  always_comb begin
    wr_be    = 4'b1111;
    wr_lanes = WriteData_in;
    case (MemSize_in)
      2'b00: begin
        wr_be    = 4'b0001 << Addr_in[1:0];
        wr_lanes = {4{WriteData_in[7:0]}};
      end
      2'b01: begin
        wr_be    = Addr_in[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{WriteData_in[15:0]}};
      end
      default: begin
        wr_be    = 4'b1111;
        wr_lanes = WriteData_in;
      end
    endcase
  end

  // Load extraction and extension
  always_comb begin
    rd_word  = mem[word_idx];
    rd_byte  = rd_word[7:0];
    rd_half  = Addr_in[1] ? rd_word[31:16] : rd_word[15:0];
    load_ext = rd_word;
    case (Addr_in[1:0])
      2'b00:   rd_byte = rd_word[7:0];
      2'b01:   rd_byte = rd_word[15:8];
      2'b10:   rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    case (MemSize_in)
      2'b00:   load_ext = MemUnsigned_in ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = MemUnsigned_in ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: load_ext = rd_word;
    endcase
  end

  // ---------------------------------------------------------------- RAM
  // Commit happens only on the edge entering DONE. A reset on that edge aborts the store.
  always_ff @(posedge clk) begin
    if (!reset && enter_done && is_store) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem[word_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------- result register
  always_ff @(posedge clk) begin
    if (reset) begin
      ReadData_out <= 32'd0;
    end else if (misalign) begin
      ReadData_out <= 32'd0;
    end else if (enter_done) begin
      ReadData_out <= is_store ? 32'd0 : load_ext;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=0.
// Expected results are pushed into per-instance queues when a request is driven.
// A monitor per instance pops and compares them when it sees a DONE cycle (stall falls while req is held).
module tb_mem_access_stage;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  req_t        in_a = '0;
  req_t        in_b = '0;
  logic [31:0] rd_a, rd_b;
  logic        st_a, st_b, mis_a, mis_b;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] last_a = 32'd0;
  logic [31:0] last_b = 32'd0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_BITS(10), .WAIT_CYCLES(1)) dut_a (
    .clk(clk), .reset(reset),
    .MemRead_in(in_a.rd), .MemWrite_in(in_a.wr), .MemSize_in(in_a.size),
    .MemUnsigned_in(in_a.uns), .Addr_in(in_a.addr), .WriteData_in(in_a.wdata),
    .ReadData_out(rd_a), .Stall_out(st_a), .Misalign_out(mis_a)
  );

  mem_access_stage #(.ADDR_BITS(10), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset),
    .MemRead_in(in_b.rd), .MemWrite_in(in_b.wr), .MemSize_in(in_b.size),
    .MemUnsigned_in(in_b.uns), .Addr_in(in_b.addr), .WriteData_in(in_b.wdata),
    .ReadData_out(rd_b), .Stall_out(st_b), .Misalign_out(mis_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitors
  int   sc_a = 0, sc_b = 0;
  logic ps_a = 1'b0, ps_b = 1'b0;

  always @(negedge clk) begin
    if (reset || !(in_a.rd || in_a.wr)) begin
      sc_a <= 0;
    end else if (st_a) begin
      sc_a <= sc_a + 1;
    end else if (ps_a) begin
      if (qa.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL a_unexpected_done: result 0x%08h with nothing expected", rd_a);
      end else begin
        chk("a_rdata", rd_a, qa.pop_front());
        chk("a_stall_cycles", sc_a, 32'd2);
      end
      sc_a <= 0;
    end
    ps_a <= st_a && !reset;
  end

  always @(negedge clk) begin
    if (reset || !(in_b.rd || in_b.wr)) begin
      sc_b <= 0;
    end else if (st_b) begin
      sc_b <= sc_b + 1;
    end else if (ps_b) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL b_unexpected_done: result 0x%08h with nothing expected", rd_b);
      end else begin
        chk("b_rdata", rd_b, qb.pop_front());
        chk("b_stall_cycles", sc_b, 32'd1);
      end
      sc_b <= 0;
    end
    ps_b <= st_b && !reset;
  end

  // ---------------------------------------------------------------- stimulus helpers
  function automatic req_t mk(input logic rd, input logic wr, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    r.rd = rd; r.wr = wr; r.size = size; r.uns = uns; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  // Drives one access and holds it for the stall-free length, WAIT+2 cycles.
  // Called consecutively, the next request is presented in the cycle after DONE.
  task automatic acc(input int d, input req_t r, input logic [31:0] exp);
    if (d == 0) begin
      in_a = r;
      qa.push_back(exp);
    end else begin
      in_b = r;
      qb.push_back(exp);
    end
    @(negedge clk);
    if (d == 0) begin
      chk("a_hold_prev", rd_a, last_a);
      chk("a_stall_req_cycle", {31'd0, st_a}, 32'd1);
    end else begin
      chk("b_hold_prev", rd_b, last_b);
      chk("b_stall_req_cycle", {31'd0, st_b}, 32'd1);
    end
    repeat ((d == 0) ? 3 : 2) @(posedge clk);
    #1;
    if (d == 0) last_a = exp; else last_b = exp;
  endtask

  task automatic idle(input int n);
    in_a = '0;
    in_b = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- directed sequence
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("a_reset_rdata", rd_a, 32'd0);
    chk("a_reset_stall", {31'd0, st_a}, 32'd0);
    chk("a_reset_misalign", {31'd0, mis_a}, 32'd0);
    chk("b_reset_rdata", rd_b, 32'd0);
    chk("b_reset_stall", {31'd0, st_b}, 32'd0);
    @(posedge clk); #1;

    // WAIT_CYCLES=0: back-to-back accesses, wrap aliasing
    acc(1, mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h01020304), 32'h0);
    acc(1, mk(1'b1, 1'b0, 2'b00, 1'b1, 32'h10, 32'h0), 32'h00000004);
    acc(1, mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0), 32'h00000102);
    acc(1, mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h1010, 32'h0), 32'h01020304);
    idle(2);
    @(negedge clk);
    chk("b_idle_hold", rd_b, 32'h01020304);
    chk("b_idle_stall", {31'd0, st_b}, 32'd0);
    @(posedge clk); #1;

    // WAIT_CYCLES=1
    acc(0, mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF), 32'h0);
    acc(0, mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0), 32'hDEADBEEF);
    idle(2);
    @(negedge clk);
    chk("a_idle_hold", rd_a, 32'hDEADBEEF);
    chk("a_idle_stall", {31'd0, st_a}, 32'd0);
    @(posedge clk); #1;
    acc(0, mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0), 32'hFFFFFFBE);
    acc(0, mk(1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0), 32'h000000BE);
    acc(0, mk(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0), 32'hFFFFDEAD);
    acc(0, mk(1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0), 32'h0000BEEF);
    acc(0, mk(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'hAABBCC55), 32'h0);
    acc(0, mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0), 32'h55ADBEEF);
    acc(0, mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 32'h11223344), 32'h0);
    acc(0, mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF1234), 32'h0);
    acc(0, mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0), 32'h12343344);
    acc(0, mk(1'b1, 1'b0, 2'b00, 1'b0, 32'h17, 32'h0), 32'h00000012);
    // Read and write together: treated as a store only
    acc(0, mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h18, 32'hCAFEF00D), 32'h0);
    acc(0, mk(1'b1, 1'b0, 2'b11, 1'b0, 32'h18, 32'h0), 32'hCAFEF00D);
    acc(0, mk(1'b1, 1'b0, 2'b11, 1'b0, 32'h1010, 32'h0), 32'h55ADBEEF);
    idle(1);

    // Reset during WAIT of a store: no commit
    acc(0, mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5A5A5), 32'h0);
    in_a = mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    in_a = '0;
    last_a = 32'd0;
    @(negedge clk);
    chk("a_after_reset_stall", {31'd0, st_a}, 32'd0);
    chk("a_after_reset_rdata", rd_a, 32'd0);
    @(posedge clk); #1;
    acc(0, mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0), 32'hA5A5A5A5);
    idle(1);

    // Misaligned word store at 0x22
`ifdef MEM_MISALIGN_TRAP_EN
    in_a = mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h22, 32'h0BADF00D);
    @(negedge clk);
    chk("a_misalign_flag", {31'd0, mis_a}, 32'd1);
    chk("a_misalign_stall", {31'd0, st_a}, 32'd0);
    @(posedge clk); #1;
    in_a = '0;
    last_a = 32'd0;
    @(negedge clk);
    chk("a_misalign_rdata", rd_a, 32'd0);
    @(posedge clk); #1;
    acc(0, mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0), 32'hA5A5A5A5);
`else
    acc(0, mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h22, 32'h0BADF00D), 32'h0);
    @(negedge clk);
    chk("a_misalign_flag", {31'd0, mis_a}, 32'd0);
    @(posedge clk); #1;
    acc(0, mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0), 32'h0BADF00D);
`endif
    idle(3);

    chk("a_queue_drained", qa.size(), 32'd0);
    chk("b_queue_drained", qb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
